noc_input_ctrl_buf: RTL and testbench

Clocked, buffered successor to the tree-router input controller. It accepts packets on a valid/ready port and queues them in a DEPTH-entry FIFO. Each head packet is routed to one of two output channels, either by a destination-bit decision (parent node) or by an up/down mask-and-address decision (child node). It sits at every input port of a tree NoC router, in front of the output arbiters.

---
 rtl/noc_pkg.sv | 31 +++
 rtl/noc_sync_fifo.sv | 56 +++++
 rtl/noc_input_ctrl_buf.sv | 120 ++++++++++++
 tb/tb_noc_input_ctrl_buf.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared defaults, FSM state type and route decision for tree-router blocks.
// route_is_ch1 takes zero-extended address fields plus the real address width.
package noc_pkg;

  localparam int NOC_WIDTH_PACKET = 14;
  localparam int NOC_WIDTH_ADDR   = 3;
  localparam int NOC_ADDR_MAX     = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEND1,
    SEND2
  } in_ctrl_state_t;

  // Parent: test the destination bit owned by this level (0 -> ch1).
  // Child: any mismatch outside the subtree sends the packet up (ch1).
  function automatic logic route_is_ch1(
    input logic [NOC_ADDR_MAX-1:0] dest,
    input int unsigned             level,
    input logic                    is_parent,
    input logic [NOC_ADDR_MAX-1:0] mask,
    input logic [NOC_ADDR_MAX-1:0] addr,
    input int unsigned             width_addr
  );
    logic [NOC_ADDR_MAX-1:0] sh;
    sh = dest >> (width_addr - 1 - level);
    if (is_parent) return !sh[0];
    return ((dest ^ addr) & mask) != '0;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: DEPTH-entry synchronous FIFO, any DEPTH >= 2.
// Ports: push/wdata in, pop in, rdata = head, full/empty/count status.
module noc_sync_fifo #(
  parameter  int WIDTH = 14,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem[rd_q];
  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push)
        wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
      if (do_pop)
        rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
      if (do_push && !do_pop)
        cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push)
        cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= wdata;
  end

endmodule

// File: rtl/noc_input_ctrl_buf.sv
// noc_input_ctrl_buf: buffered tree-router input port; FIFO + 1-entry output register
// steering each head packet to out1/out2. Ports: in_* valid/ready, out1_*/out2_*
// valid/ready/data, occupancy. `ROUTE_STATS_EN adds stats_clr, out1_cnt, out2_cnt.
module noc_input_ctrl_buf
  import noc_pkg::*;
#(
  parameter int                    WIDTH_PACKET = NOC_WIDTH_PACKET,
  parameter int                    WIDTH_ADDR   = NOC_WIDTH_ADDR,
  parameter int                    LEVEL        = 0,
  parameter bit                    IS_PARENT    = 1'b0,
  parameter logic [WIDTH_ADDR-1:0] MASK         = 3'b110,
  parameter logic [WIDTH_ADDR-1:0] ADDR         = 3'b000,
  parameter int                    DEPTH        = 4,
  localparam int                   OW           = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH_PACKET-1:0] in_data,
  output logic                    out1_valid,
  input  logic                    out1_ready,
  output logic [WIDTH_PACKET-1:0] out1_data,
  output logic                    out2_valid,
  input  logic                    out2_ready,
  output logic [WIDTH_PACKET-1:0] out2_data,
`ifdef ROUTE_STATS_EN
  input  logic                    stats_clr,
  output logic [15:0]             out1_cnt,
  output logic [15:0]             out2_cnt,
`endif
  output logic [OW-1:0]           occupancy
);

  in_ctrl_state_t state_q;
  in_ctrl_state_t state_d;

  logic [WIDTH_PACKET-1:0] head;
  logic [WIDTH_PACKET-1:0] data_q;
  logic [WIDTH_ADDR-1:0]   dest;
  logic                    full;
  logic                    empty;
  logic                    pop;
  logic                    done;
  logic                    head_ch1;

  noc_sync_fifo #(
    .WIDTH (WIDTH_PACKET),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  assign in_ready = !full;
  assign dest     = head[WIDTH_PACKET-WIDTH_ADDR-1 -: WIDTH_ADDR];
  assign head_ch1 = route_is_ch1(
    NOC_ADDR_MAX'(dest), unsigned'(LEVEL), IS_PARENT,
    NOC_ADDR_MAX'(MASK), NOC_ADDR_MAX'(ADDR), unsigned'(WIDTH_ADDR));

  // done: output register is free at the next edge (idle or being taken).
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    done    = 1'b0;
    unique case (1'b1)
      state_q == SEND1: done = out1_ready;
      state_q == SEND2: done = out2_ready;
      default:          done = 1'b1;
    endcase
    if (done) begin
      if (!empty) begin
        pop     = 1'b1;
        state_d = head_ch1 ? SEND1 : SEND2;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pop) data_q <= head;
    end
  end

  assign out1_valid = (state_q == SEND1);
  assign out2_valid = (state_q == SEND2);
  assign out1_data  = data_q;
  assign out2_data  = data_q;

`ifdef ROUTE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_cnt <= '0;
      out2_cnt <= '0;
    end else if (stats_clr) begin
      out1_cnt <= '0;
      out2_cnt <= '0;
    end else begin
      if (out1_valid && out1_ready && out1_cnt != 16'hFFFF)
        out1_cnt <= out1_cnt + 16'd1;
      if (out2_valid && out2_ready && out2_cnt != 16'hFFFF)
        out2_cnt <= out2_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_input_ctrl_buf.sv
// tb_noc_input_ctrl_buf: scoreboard bench for noc_input_ctrl_buf (parent DUT plus
// two child-mode instances); `ROUTE_STATS_EN enables the counter scenario.
module tb_noc_input_ctrl_buf;

  localparam int W  = 14;
  localparam int D  = 4;
  localparam int OW = $clog2(D + 1);

  typedef struct {
    logic         ch2;
    logic [W-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [W-1:0]  out1_data;
  logic          out2_valid;
  logic          out2_ready;
  logic [W-1:0]  out2_data;
  logic [OW-1:0] occupancy;

  logic          c_in_valid   [2];
  logic          c_in_ready   [2];
  logic [W-1:0]  c_in_data    [2];
  logic          c_out1_valid [2];
  logic [W-1:0]  c_out1_data  [2];
  logic          c_out2_valid [2];
  logic [W-1:0]  c_out2_data  [2];
  logic [OW-1:0] c_occ        [2];
  logic          c_ready;

`ifdef ROUTE_STATS_EN
  logic        stats_clr;
  logic [15:0] out1_cnt;
  logic [15:0] out2_cnt;
  logic [15:0] c_cnt1 [2];
  logic [15:0] c_cnt2 [2];
`endif

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  noc_input_ctrl_buf #(
    .IS_PARENT (1'b1),
    .LEVEL     (0),
    .DEPTH     (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .out2_data  (out2_data),
`ifdef ROUTE_STATS_EN
    .stats_clr  (stats_clr),
    .out1_cnt   (out1_cnt),
    .out2_cnt   (out2_cnt),
`endif
    .occupancy  (occupancy)
  );

  noc_input_ctrl_buf #(
    .IS_PARENT (1'b0),
    .MASK      (3'b110),
    .ADDR      (3'b000),
    .DEPTH     (D)
  ) u_child0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (c_in_valid[0]),
    .in_ready   (c_in_ready[0]),
    .in_data    (c_in_data[0]),
    .out1_valid (c_out1_valid[0]),
    .out1_ready (c_ready),
    .out1_data  (c_out1_data[0]),
    .out2_valid (c_out2_valid[0]),
    .out2_ready (c_ready),
    .out2_data  (c_out2_data[0]),
`ifdef ROUTE_STATS_EN
    .stats_clr  (stats_clr),
    .out1_cnt   (c_cnt1[0]),
    .out2_cnt   (c_cnt2[0]),
`endif
    .occupancy  (c_occ[0])
  );

  noc_input_ctrl_buf #(
    .IS_PARENT (1'b0),
    .MASK      (3'b110),
    .ADDR      (3'b010),
    .DEPTH     (D)
  ) u_child2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (c_in_valid[1]),
    .in_ready   (c_in_ready[1]),
    .in_data    (c_in_data[1]),
    .out1_valid (c_out1_valid[1]),
    .out1_ready (c_ready),
    .out1_data  (c_out1_data[1]),
    .out2_valid (c_out2_valid[1]),
    .out2_ready (c_ready),
    .out2_data  (c_out2_data[1]),
`ifdef ROUTE_STATS_EN
    .stats_clr  (stats_clr),
    .out1_cnt   (c_cnt1[1]),
    .out2_cnt   (c_cnt2[1]),
`endif
    .occupancy  (c_occ[1])
  );

  // Parent at level 0: destination MSB (packet bit 10) selects channel 2.
  function automatic logic exp_ch2(input logic [W-1:0] d);
    return d[10];
  endfunction

  task automatic monitor();
    exp_t         e;
    logic [W-1:0] got;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out1_valid || out2_valid) begin
          n_chk++;
          if (out1_valid && out2_valid) begin
            n_fail++;
            $display("FAIL both_valid: got out1_valid=1 out2_valid=1 required one-hot");
          end
        end
        if ((out1_valid && out1_ready) || (out2_valid && out2_ready)) begin
          n_chk++;
          got = out2_valid ? out2_data : out1_data;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got ch2=%0b data=%h required nothing", out2_valid, got);
          end else begin
            e = sb.pop_front();
            if (out2_valid !== e.ch2 || got !== e.d) begin
              n_fail++;
              $display("FAIL sb_order: got ch2=%0b data=%h required ch2=%0b data=%h",
                       out2_valid, got, e.ch2, e.d);
            end
          end
        end
      end
    end
  endtask

  task automatic push_pkt(input logic [W-1:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{exp_ch2(d), d});
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL push_timeout: got in_ready=0 for 100 cycles required accept");
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_chk++;
    if ({in_ready, out1_valid, out2_valid, occupancy} !== {1'b1, 2'b00, OW'(0)}) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%0b v1=%0b v2=%0b occ=%0d required 1 0 0 0",
               in_ready, out1_valid, out2_valid, occupancy);
    end
    n_chk++;
    if (out1_data !== '0 || out2_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h required 0 0", out1_data, out2_data);
    end
`ifdef ROUTE_STATS_EN
    n_chk++;
    if (out1_cnt !== 16'd0 || out2_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d %0d required 0 0", out1_cnt, out2_cnt);
    end
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_parent();
    logic [W-1:0] pk [2];
    pk[0] = 14'h0300;
    pk[1] = 14'h0400;
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = pk[i];
      sb.push_back('{logic'(i == 1), pk[i]});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_chk++;
      if (out1_valid !== 1'b0 || out2_valid !== 1'b0 || occupancy !== OW'(1)) begin
        n_fail++;
        $display("FAIL parent_lat1: got v1=%0b v2=%0b occ=%0d required 0 0 1",
                 out1_valid, out2_valid, occupancy);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (out1_valid !== logic'(i == 0) || out2_valid !== logic'(i == 1)
          || out1_data !== pk[i]) begin
        n_fail++;
        $display("FAIL parent_route: got v1=%0b v2=%0b data=%h required v1=%0b data=%h",
                 out1_valid, out2_valid, out1_data, i == 0, pk[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_child();
    int           inst [5];
    logic [W-1:0] pk   [5];
    logic         ch2  [5];
    inst = '{0, 0, 1, 1, 1};
    pk   = '{14'h0100, 14'h0200, 14'h0300, 14'h0200, 14'h0600};
    ch2  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      c_in_valid[inst[i]] = 1'b1;
      c_in_data[inst[i]]  = pk[i];
      @(posedge clk);
      #1;
      c_in_valid[inst[i]] = 1'b0;
      @(posedge clk);
      #1;
      n_chk++;
      if (c_out1_valid[inst[i]] !== !ch2[i] || c_out2_valid[inst[i]] !== ch2[i]
          || c_out1_data[inst[i]] !== pk[i]) begin
        n_fail++;
        $display("FAIL child_route%0d: got v1=%0b v2=%0b data=%h required v2=%0b data=%h",
                 i, c_out1_valid[inst[i]], c_out2_valid[inst[i]],
                 c_out1_data[inst[i]], ch2[i], pk[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_full();
    bit acc;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_pkt(W'(i + 1));
    in_valid = 1'b1;
    in_data  = W'(6);
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (in_ready !== 1'b0 || occupancy !== OW'(D)) begin
      n_fail++;
      $display("FAIL full_state: got rdy=%0b occ=%0d required 0 %0d", in_ready, occupancy, D);
    end
    n_chk++;
    if (out1_valid !== 1'b1 || out2_valid !== 1'b0 || out1_data !== W'(1)) begin
      n_fail++;
      $display("FAIL full_hold: got v1=%0b v2=%0b data=%h required 1 0 0001",
               out1_valid, out2_valid, out1_data);
    end
    out1_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      acc = 1'b0;
      @(negedge clk);
      n_chk++;
      if (out1_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL full_drain%0d: got v1=%0b required 1", i, out1_valid);
      end
      if (in_valid && in_ready) begin
        sb.push_back('{1'b0, W'(6)});
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc) in_valid = 1'b0;
    end
    @(negedge clk);
    n_chk++;
    if (out1_valid !== 1'b0 || occupancy !== OW'(0) || in_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_empty: got v1=%0b occ=%0d inv=%0b required 0 0 0",
               out1_valid, occupancy, in_valid);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      if (j < 8) begin
        in_valid = 1'b1;
        in_data  = (j % 2 == 1) ? (14'h0400 | W'(j)) : W'(j);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (j < 8) begin
        n_chk++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready%0d: got 0 required 1", j);
        end
        sb.push_back('{logic'(j % 2 == 1), in_data});
      end
      if (j >= 2) begin
        n_chk++;
        if (out1_valid !== logic'((j - 2) % 2 == 0) || out2_valid !== logic'((j - 2) % 2 == 1)) begin
          n_fail++;
          $display("FAIL b2b_slot%0d: got v1=%0b v2=%0b required v1=%0b",
                   j - 2, out1_valid, out2_valid, (j - 2) % 2 == 0);
        end
      end
      @(posedge clk);
      #1;
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    out1_ready = 1'b1;
    out2_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_pkt(14'h0400 | W'(i));
    @(posedge clk);
    #1;
    n_chk++;
    if (out2_valid !== 1'b1 || occupancy !== OW'(3)) begin
      n_fail++;
      $display("FAIL rstmid_pre: got v2=%0b occ=%0d required 1 3", out2_valid, occupancy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_chk++;
    if (out2_valid !== 1'b0 || occupancy !== OW'(0) || in_ready !== 1'b1
        || out2_data !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: got v2=%0b occ=%0d rdy=%0b data=%h required 0 0 1 0",
               out2_valid, occupancy, in_ready, out2_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out2_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if (out1_valid !== 1'b0 || out2_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rstmid_quiet%0d: got v1=%0b v2=%0b rdy=%0b required 0 0 1",
                 i, out1_valid, out2_valid, in_ready);
      end
    end
    @(posedge clk);
    #1;
  endtask

`ifdef ROUTE_STATS_EN
  task automatic test_stats();
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      push_pkt(i < 5 ? W'(i) : (14'h0400 | W'(i)));
    wait_drain();
    n_chk++;
    if (out1_cnt !== 16'd5 || out2_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL stats_count: got %0d %0d required 5 3", out1_cnt, out2_cnt);
    end
    push_pkt(W'(9));
    @(posedge clk);
    #1;
    n_chk++;
    if (out1_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stats_clr_pre: got v1=%0b required 1", out1_valid);
    end
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    n_chk++;
    if (out1_cnt !== 16'd0 || out2_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_clr: got %0d %0d required 0 0", out1_cnt, out2_cnt);
    end
    in_valid = 1'b1;
    in_data  = W'(5);
    for (int n = 0; n < 65540; n++) begin
      @(negedge clk);
      if (in_ready) sb.push_back('{1'b0, W'(5)});
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_drain();
    n_chk++;
    if (out1_cnt !== 16'hFFFF || out2_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_sat: got %h %h required ffff 0000", out1_cnt, out2_cnt);
    end
  endtask
`endif

  initial begin
    in_valid   = 1'b0;
    in_data    = '0;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    c_ready    = 1'b1;
    for (int k = 0; k < 2; k++) begin
      c_in_valid[k] = 1'b0;
      c_in_data[k]  = '0;
    end
`ifdef ROUTE_STATS_EN
    stats_clr = 1'b0;
`endif
    fork
      monitor();
    join_none
    test_reset();
    test_parent();
    test_child();
    test_full();
    test_back_to_back();
    test_reset_mid();
`ifdef ROUTE_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
